// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver with a 2-bit saturating direction predictor.
// Resolves RV64 conditional branches and JAL/JALR targets, issues a one-cycle
// registered redirect on mispredict and holds a flush window afterwards.
// Optional build macro: BRANCH_RESOLVE_STATS_EN enables the saturating
// branch/mispredict statistics counters; otherwise both stat ports read zero.
module branch_resolve_unit #(
   parameter int XLEN         = 64,
   parameter int BHT_ENTRIES  = 16,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic            clk_in,
   input  logic            reset_in,
   input  logic [XLEN-1:0] fetch_pc_in,
   output logic            predict_taken_out,
   input  logic            valid_in,
   input  logic [XLEN-1:0] pc_in,
   input  logic [XLEN-1:0] rs1_value_in,
   input  logic [XLEN-1:0] rs2_value_in,
   input  logic [XLEN-1:0] imm_value_in,
   input  logic [2:0]      funct3_in,
   input  logic            branch_signal_in,
   input  logic            jump_signal_in,
   input  logic            pc_src_signal_in,
   input  logic            pred_taken_in,
   output logic            redirect_valid_out,
   output logic [XLEN-1:0] redirect_pc_out,
   output logic            flush_busy_out,
   output logic [31:0]     branch_count_out,
   output logic [31:0]     mispredict_count_out
);

   localparam int IDX = $clog2(BHT_ENTRIES);
   localparam int CW  = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CW-1:0] FLUSH_LOAD = CW'(FLUSH_CYCLES);

   logic [1:0]      bht [BHT_ENTRIES];
   logic [CW-1:0]   flush_cnt;
   logic [IDX-1:0]  fetch_idx;
   logic [IDX-1:0]  upd_idx;

   logic            cond;
   logic            f3_ok;
   logic            taken;
   logic            mispredict;
   logic            accept;
   logic            do_redirect;
   logic            bht_upd;
   logic [XLEN-1:0] base;
   logic [XLEN-1:0] sum;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] fall_through;

   // Only the index bits of the fetch PC take part in the lookup.
   logic unused_fetch_bits;
   assign unused_fetch_bits = ^{fetch_pc_in[XLEN-1:IDX+2], fetch_pc_in[1:0]};

   assign fetch_idx         = fetch_pc_in[IDX+1:2];
   assign upd_idx           = pc_in[IDX+1:2];
   assign predict_taken_out = bht[fetch_idx][1];
   assign flush_busy_out    = (flush_cnt != '0);

   // Branch condition decode; 010/011 are not branches and never train the BHT.
   always_comb begin
      cond  = 1'b0;
      f3_ok = 1'b1;
      case (funct3_in)
         3'b000:  cond = (rs1_value_in == rs2_value_in);
         3'b001:  cond = (rs1_value_in != rs2_value_in);
         3'b100:  cond = ($signed(rs1_value_in) <  $signed(rs2_value_in));
         3'b101:  cond = ($signed(rs1_value_in) >= $signed(rs2_value_in));
         3'b110:  cond = (rs1_value_in <  rs2_value_in);
         3'b111:  cond = (rs1_value_in >= rs2_value_in);
         default: begin
            cond  = 1'b0;
            f3_ok = 1'b0;
         end
      endcase
   end

   // Target, direction and mispredict resolution; JALR clears bit 0 and always redirects.
   always_comb begin
      base         = pc_src_signal_in ? rs1_value_in : pc_in;
      sum          = base + imm_value_in;
      target       = {sum[XLEN-1:1], sum[0] & ~pc_src_signal_in};
      fall_through = pc_in + XLEN'(4);
      taken        = jump_signal_in | (branch_signal_in & cond);
      mispredict   = (taken != pred_taken_in) | (jump_signal_in & pc_src_signal_in);
      accept       = valid_in & ~flush_busy_out & (branch_signal_in | jump_signal_in);
      do_redirect  = accept & mispredict;
      bht_upd      = accept & branch_signal_in & ~jump_signal_in & f3_ok;
   end

   // Redirect pulse, corrected PC and flush window counter.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         redirect_valid_out <= 1'b0;
         redirect_pc_out    <= '0;
         flush_cnt          <= '0;
      end else begin
         redirect_valid_out <= do_redirect;
         if (do_redirect) begin
            redirect_pc_out <= taken ? target : fall_through;
            flush_cnt       <= FLUSH_LOAD;
         end else if (flush_cnt != '0) begin
            flush_cnt <= flush_cnt - 1'b1;
         end
      end
   end

   // Saturating 2-bit predictor training; reset leaves every entry weakly not-taken.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht[i] <= 2'b01;
         end
      end else if (bht_upd) begin
         if (taken) begin
            if (bht[upd_idx] != 2'b11) bht[upd_idx] <= bht[upd_idx] + 2'b01;
         end else begin
            if (bht[upd_idx] != 2'b00) bht[upd_idx] <= bht[upd_idx] - 2'b01;
         end
      end
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] branch_cnt;
   logic [31:0] mispred_cnt;

   assign branch_count_out     = branch_cnt;
   assign mispredict_count_out = mispred_cnt;

   // Saturating statistics: trained branches and issued redirects.
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         if (bht_upd && branch_cnt != 32'hFFFF_FFFF) branch_cnt <= branch_cnt + 32'd1;
         if (do_redirect && mispred_cnt != 32'hFFFF_FFFF) mispred_cnt <= mispred_cnt + 32'd1;
      end
   end
`else
   assign branch_count_out     = 32'd0;
   assign mispredict_count_out = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: the driver runs a behavioural model
// and queues the expected registered outputs; a monitor pops and compares them.
module tb_branch_resolve_unit;

   localparam int XLEN  = 64;
   localparam int NBHT  = 16;
   localparam int FLUSH = 2;

   logic            clk_in = 1'b0;
   logic            reset_in;
   logic [XLEN-1:0] fetch_pc_in;
   logic            predict_taken_out;
   logic            valid_in;
   logic [XLEN-1:0] pc_in, rs1_value_in, rs2_value_in, imm_value_in;
   logic [2:0]      funct3_in;
   logic            branch_signal_in, jump_signal_in, pc_src_signal_in, pred_taken_in;
   logic            redirect_valid_out;
   logic [XLEN-1:0] redirect_pc_out;
   logic            flush_busy_out;
   logic [31:0]     branch_count_out, mispredict_count_out;

   branch_resolve_unit #(.XLEN(XLEN), .BHT_ENTRIES(NBHT), .FLUSH_CYCLES(FLUSH)) dut (
      .clk_in(clk_in), .reset_in(reset_in), .fetch_pc_in(fetch_pc_in),
      .predict_taken_out(predict_taken_out), .valid_in(valid_in), .pc_in(pc_in),
      .rs1_value_in(rs1_value_in), .rs2_value_in(rs2_value_in), .imm_value_in(imm_value_in),
      .funct3_in(funct3_in), .branch_signal_in(branch_signal_in), .jump_signal_in(jump_signal_in),
      .pc_src_signal_in(pc_src_signal_in), .pred_taken_in(pred_taken_in),
      .redirect_valid_out(redirect_valid_out), .redirect_pc_out(redirect_pc_out),
      .flush_busy_out(flush_busy_out), .branch_count_out(branch_count_out),
      .mispredict_count_out(mispredict_count_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic            rv;
      logic [XLEN-1:0] rpc;
      logic            busy;
      logic [31:0]     bc;
      logic [31:0]     mc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // reference model state
   int              m_bht[NBHT];
   int              m_busy;
   logic [XLEN-1:0] m_rpc;
   longint          m_bc, m_mc;
   bit              m_known = 0;

   task automatic issue(input logic rst, input logic v, input logic [XLEN-1:0] pc,
                        input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2,
                        input logic [XLEN-1:0] imm, input logic [2:0] f3,
                        input logic br, input logic j, input logic src, input logic pred,
                        input logic [XLEN-1:0] fpc);
      exp_t            e;
      bit              acc, cond, f3ok, tk, misp, rv;
      logic [XLEN-1:0] tgt;
      int              idx;
      @(negedge clk_in);
      reset_in = rst; valid_in = v; pc_in = pc; rs1_value_in = r1; rs2_value_in = r2;
      imm_value_in = imm; funct3_in = f3; branch_signal_in = br; jump_signal_in = j;
      pc_src_signal_in = src; pred_taken_in = pred; fetch_pc_in = fpc;
      #1;
      if (m_known) begin
         n_cmp++;
         if (predict_taken_out !== (m_bht[(fpc >> 2) % NBHT] >= 2)) begin
            n_err++;
            $display("FAIL predict fpc=%h got=%b want=%b", fpc, predict_taken_out,
                     m_bht[(fpc >> 2) % NBHT] >= 2);
         end
      end
      if (rst) begin
         foreach (m_bht[i]) m_bht[i] = 1;
         m_busy = 0; m_rpc = '0; m_bc = 0; m_mc = 0; m_known = 1;
         rv = 0;
      end else begin
         acc  = v && (m_busy == 0) && (br || j);
         f3ok = 1;
         case (f3)
            3'd0: cond = (r1 == r2);
            3'd1: cond = (r1 != r2);
            3'd4: cond = ($signed(r1) <  $signed(r2));
            3'd5: cond = ($signed(r1) >= $signed(r2));
            3'd6: cond = (r1 <  r2);
            3'd7: cond = (r1 >= r2);
            default: begin cond = 0; f3ok = 0; end
         endcase
         tk   = j || (br && cond);
         tgt  = (src ? r1 : pc) + imm;
         if (src) tgt[0] = 1'b0;
         misp = (tk != pred) || (j && src);
         rv   = acc && misp;
         if (rv) m_rpc = tk ? tgt : pc + 64'd4;
         m_busy = rv ? FLUSH : (m_busy > 0 ? m_busy - 1 : 0);
         if (acc && br && !j && f3ok) begin
            idx = int'((pc >> 2) % NBHT);
            m_bht[idx] = tk ? ((m_bht[idx] < 3) ? m_bht[idx] + 1 : 3)
                            : ((m_bht[idx] > 0) ? m_bht[idx] - 1 : 0);
`ifdef BRANCH_RESOLVE_STATS_EN
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
`endif
         end
`ifdef BRANCH_RESOLVE_STATS_EN
         if (rv && m_mc < 64'hFFFF_FFFF) m_mc++;
`endif
      end
      e.rv = rv; e.rpc = m_rpc; e.busy = (m_busy != 0);
      e.bc = 32'(m_bc); e.mc = 32'(m_mc);
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n, input logic [XLEN-1:0] fpc);
      for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fpc);
   endtask

   function automatic logic [XLEN-1:0] pick_val();
      logic [XLEN-1:0] v;
      case ($urandom_range(0, 4))
         0: v = 64'd0;
         1: v = 64'd1;
         2: v = '1;
         3: v = 64'(signed'($urandom_range(0, 7)) - 3);
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   // Monitor: one expected entry per driven cycle, checked just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_in);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (redirect_valid_out !== e.rv || flush_busy_out !== e.busy ||
                (e.rv && redirect_pc_out !== e.rpc) || redirect_pc_out !== e.rpc) begin
               n_err++;
               $display("FAIL redirect got v=%b pc=%h busy=%b want v=%b pc=%h busy=%b",
                        redirect_valid_out, redirect_pc_out, flush_busy_out, e.rv, e.rpc, e.busy);
            end
            n_cmp++;
            if (branch_count_out !== e.bc || mispredict_count_out !== e.mc) begin
               n_err++;
               $display("FAIL stats got bc=%0d mc=%0d want bc=%0d mc=%0d",
                        branch_count_out, mispredict_count_out, e.bc, e.mc);
            end
         end
      end
   end

   initial begin
      int budget;
      logic [XLEN-1:0] pc, fpc;
      logic br, j;
      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // BEQ taken but predicted not-taken: redirect to 0x140, flush two cycles
      issue(0, 1, 64'h100, 5, 5, 64'h40, 3'b000, 1, 0, 0, 0, 64'h100);
      idle(3, 64'h100);
      // BNE not taken from a freshly reset entry
      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      issue(0, 1, 64'h200, 7, 7, 64'h20, 3'b001, 1, 0, 0, 0, 64'h200);
      idle(1, 64'h200);
      // BLT signed taken vs BLTU unsigned not-taken, both predicted taken
      issue(0, 1, 64'h400, '1, 1, 64'h80, 3'b100, 1, 0, 0, 1, 64'h400);
      issue(0, 1, 64'h404, '1, 1, 64'h80, 3'b110, 1, 0, 0, 1, 64'h404);
      idle(3, 64'h404);
      // JALR with odd sum, then a request inside the flush window
      issue(0, 1, 64'h500, 64'h1001, 0, 64'h10, 3'b000, 0, 1, 1, 1, 64'h500);
      issue(0, 1, 64'h500, 3, 3, 64'h40, 3'b000, 1, 0, 0, 0, 64'h500);
      idle(3, 64'h500);
      // four taken BGE on one entry; lookups see the pre-update value
      for (int i = 0; i < 4; i++)
         issue(0, 1, 64'h300, 3, 3, 64'h8, 3'b101, 1, 0, 0, 1, 64'h300);
      idle(1, 64'h300);
      // reset in the middle of a flush window
      issue(0, 1, 64'h600, 1, 2, 64'h10, 3'b000, 1, 0, 0, 1, 64'h600);
      issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h600);
      issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 64'h600);
      idle(2, 64'h600);
      // random traffic over a small PC pool so entries collide
      for (int i = 0; i < 600; i++) begin
         pc  = 64'($urandom_range(0, 47)) << 2;
         if ($urandom_range(0, 7) == 0) pc[40:20] = 21'($urandom);
         fpc = 64'($urandom_range(0, 47)) << 2;
         br  = 1'($urandom_range(0, 3) != 0);
         j   = 1'($urandom_range(0, 4) == 0);
         issue(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) != 0), pc,
               pick_val(), pick_val(), 64'(signed'($urandom_range(0, 255)) - 128),
               3'($urandom), br, j, 1'($urandom), 1'($urandom), fpc);
      end
      budget = 0;
      while (exp_q.size() > 0 && budget < 20) begin
         @(posedge clk_in);
         budget++;
      end
      #2;
      if (exp_q.size() > 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain got=%0d entries left want=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
